// File: rtl/sd_pkg.sv
// Shared constants and types for the SD command-line engine and its helpers.
package sd_pkg;

   localparam logic [2:0] ADDR_ARG      = 3'd0;
   localparam logic [2:0] ADDR_CMD      = 3'd1;
   localparam logic [2:0] ADDR_STATUS   = 3'd2;
   localparam logic [2:0] ADDR_RESP     = 3'd3;
   localparam logic [2:0] ADDR_RESP_IDX = 3'd4;

   localparam int unsigned ST_BUSY    = 0;
   localparam int unsigned ST_TIMEOUT = 1;
   localparam int unsigned ST_CRC_ERR = 2;
   localparam int unsigned ST_DONE    = 3;

   localparam int unsigned FRAME_LEN  = 48;
   // Number of leading frame bits covered by CRC7.
   localparam int unsigned CRC_SPAN   = 40;
   localparam int unsigned NRC_CYCLES = 8;

   // x^7 + x^3 + 1
   localparam logic [6:0] CRC7_POLY = 7'h09;

   typedef enum logic [2:0] {StIdle, StTx, StNcr, StRx, StNrc} sd_state_e;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one bit per enabled clk; clear has priority over enable.
module sd_crc7
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       enable,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic [6:0] crc_q, crc_d;
   logic       fb;

   always_comb begin
      fb    = bit_in ^ crc_q[6];
      crc_d = crc_q;
      if (clear) begin
         crc_d = '0;
      end else if (enable) begin
         crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: Avalon register slave that sends a 48-bit command frame
// and optionally collects a 48-bit response, with CRC7 and Ncr timeout.
module sd_cmd_engine
   import sd_pkg::*;
#(
   parameter int unsigned CLK_DIV = 50,
   parameter int unsigned NCR_MAX = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        sd_clk,
   output logic        cmd_out,
   output logic        cmd_oe,
   input  logic        cmd_in
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned NcrW = $clog2(NCR_MAX + 1);

   sd_state_e       state_q, state_d;
   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic            sd_clk_q, sd_clk_d;
   logic [31:0]     arg_q, arg_d, cmd_q, cmd_d, resp_q, resp_d, readdata_q, readdata_d;
   logic [5:0]      resp_idx_q, resp_idx_d;
   logic            timeout_q, timeout_d, crc_err_q, crc_err_d, done_q, done_d;
   logic [39:0]     tx_sr_q, tx_sr_d;
   logic [44:0]     rx_sr_q, rx_sr_d;
   logic [5:0]      bit_cnt_q, bit_cnt_d;
   logic [NcrW-1:0] ncr_cnt_q, ncr_cnt_d;
   logic            cmd_out_q, cmd_out_d, cmd_oe_q, cmd_oe_d;
   logic            busy, wr_en, tick, rise, fall;
   logic            crc_clear, crc_en, crc_bit;
   logic [6:0]      crc;
   logic [31:0]     status;

   assign busy  = (state_q != StIdle);
   assign wr_en = chipselect && !write_n;
   assign tick  = busy && (div_cnt_q == DivW'(CLK_DIV - 1));
   assign rise  = tick && !sd_clk_q;
   assign fall  = tick && sd_clk_q;

   sd_crc7 u_crc7 (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (crc_clear),
      .enable  (crc_en),
      .bit_in  (crc_bit),
      .crc     (crc)
   );

   always_comb begin
      status              = '0;
      status[ST_BUSY]     = busy;
      status[ST_TIMEOUT]  = timeout_q;
      status[ST_CRC_ERR]  = crc_err_q;
      status[ST_DONE]     = done_q;
   end

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = '0;
      sd_clk_d   = 1'b0;
      arg_d      = arg_q;
      cmd_d      = cmd_q;
      resp_d     = resp_q;
      resp_idx_d = resp_idx_q;
      timeout_d  = timeout_q;
      crc_err_d  = crc_err_q;
      done_d     = done_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      bit_cnt_d  = bit_cnt_q;
      ncr_cnt_d  = ncr_cnt_q;
      cmd_out_d  = cmd_out_q;
      cmd_oe_d   = cmd_oe_q;
      crc_clear  = 1'b0;
      crc_en     = 1'b0;
      crc_bit    = 1'b0;

      if (busy) begin
         div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
         sd_clk_d  = tick ? !sd_clk_q : sd_clk_q;
      end

      if (wr_en && !busy) begin
         if (address == ADDR_ARG) begin
            arg_d = writedata;
         end else if (address == ADDR_CMD) begin
            cmd_d     = writedata;
            state_d   = StTx;
            timeout_d = 1'b0;
            crc_err_d = 1'b0;
            done_d    = 1'b0;
            tx_sr_d   = {2'b01, writedata[5:0], arg_q};
            bit_cnt_d = '0;
            crc_clear = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: ;
         StTx: begin
            if (fall) begin
               if (bit_cnt_q == 6'(FRAME_LEN)) begin
                  cmd_oe_d  = 1'b0;
                  cmd_out_d = 1'b1;
                  bit_cnt_d = '0;
                  ncr_cnt_d = '0;
                  crc_clear = 1'b1;
                  state_d   = cmd_q[8] ? StNcr : StNrc;
               end else begin
                  cmd_oe_d  = 1'b1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 6'(CRC_SPAN)) begin
                     // CRC is final here; reload the shifter with CRC tail and end bit.
                     cmd_out_d = crc[6];
                     tx_sr_d   = {crc[5:0], 1'b1, 33'd0};
                  end else begin
                     cmd_out_d = tx_sr_q[39];
                     tx_sr_d   = {tx_sr_q[38:0], 1'b0};
                     crc_en    = (bit_cnt_q < 6'(CRC_SPAN));
                     crc_bit   = tx_sr_q[39];
                  end
               end
            end
         end
         StNcr: begin
            if (rise) begin
               if (!cmd_in) begin
                  state_d   = StRx;
                  bit_cnt_d = 6'd1;
                  crc_en    = 1'b1;
                  crc_bit   = 1'b0;
               end else if (ncr_cnt_q == NcrW'(NCR_MAX - 1)) begin
                  timeout_d = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = StNrc;
               end else begin
                  ncr_cnt_d = ncr_cnt_q + 1'b1;
               end
            end
         end
         StRx: begin
            if (rise) begin
               rx_sr_d = {rx_sr_q[43:0], cmd_in};
               if (bit_cnt_q < 6'(CRC_SPAN)) begin
                  crc_en  = 1'b1;
                  crc_bit = cmd_in;
               end
               if (bit_cnt_q == 6'(FRAME_LEN - 1)) begin
                  // rx_sr_q[k-1] holds response bit k; cmd_in is the end bit.
                  resp_d     = rx_sr_q[38:7];
                  resp_idx_d = rx_sr_q[44:39];
                  crc_err_d  = (!cmd_q[9] && (rx_sr_q[6:0] != crc)) || !cmd_in;
                  bit_cnt_d  = '0;
                  state_d    = StNrc;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         StNrc: begin
            if (rise && (bit_cnt_q < 6'(NRC_CYCLES))) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            // Finish on the falling edge that closes the last Nrc cycle, leaving sd_clk low.
            if (fall && (bit_cnt_q == 6'(NRC_CYCLES))) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      unique case (address)
         ADDR_ARG:      readdata_d = arg_q;
         ADDR_CMD:      readdata_d = cmd_q;
         ADDR_STATUS:   readdata_d = status;
         ADDR_RESP:     readdata_d = resp_q;
         ADDR_RESP_IDX: readdata_d = {26'd0, resp_idx_q};
         default:       readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         div_cnt_q  <= '0;
         sd_clk_q   <= 1'b0;
         arg_q      <= '0;
         cmd_q      <= '0;
         resp_q     <= '0;
         resp_idx_q <= '0;
         timeout_q  <= 1'b0;
         crc_err_q  <= 1'b0;
         done_q     <= 1'b0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         bit_cnt_q  <= '0;
         ncr_cnt_q  <= '0;
         cmd_out_q  <= 1'b1;
         cmd_oe_q   <= 1'b0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         sd_clk_q   <= sd_clk_d;
         arg_q      <= arg_d;
         cmd_q      <= cmd_d;
         resp_q     <= resp_d;
         resp_idx_q <= resp_idx_d;
         timeout_q  <= timeout_d;
         crc_err_q  <= crc_err_d;
         done_q     <= done_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         bit_cnt_q  <= bit_cnt_d;
         ncr_cnt_q  <= ncr_cnt_d;
         cmd_out_q  <= cmd_out_d;
         cmd_oe_q   <= cmd_oe_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign sd_clk   = sd_clk_q;
   assign cmd_out  = cmd_out_q;
   assign cmd_oe   = cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: stimulus queues expected frames/reads/checks,
// a single monitor process pops and compares them.
module tb_sd_cmd_engine;

   localparam int unsigned ClkDiv = 4;
   localparam int unsigned Budget = 3000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect, write_n, cmd_in;
   logic [31:0] writedata, readdata;
   logic        sd_clk, cmd_out, cmd_oe;

   sd_cmd_engine #(.CLK_DIV(ClkDiv), .NCR_MAX(64)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .sd_clk     (sd_clk),
      .cmd_out    (cmd_out),
      .cmd_oe     (cmd_oe),
      .cmd_in     (cmd_in)
   );

   always #5 clk = ~clk;

   // Scoreboard queues
   logic [47:0] fr_exp_q[$];
   logic [31:0] rd_exp_q[$];
   string       rd_name_q[$];
   logic [63:0] ck_act_q[$];
   logic [63:0] ck_exp_q[$];
   string       ck_name_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   logic rd_strobe = 1'b0;
   logic rd_valid = 1'b0;

   always @(posedge clk) rd_valid <= rd_strobe;

   // Monitor
   logic [47:0] fr_bits = '0;
   int          fr_n = 0;
   logic        mon_sd_prev = 1'b0;
   always @(negedge clk) begin
      logic [47:0] fe;
      logic [31:0] re;
      string       nm;
      logic [63:0] a, e;
      if (!reset_n) begin
         fr_n = 0;
      end else if (sd_clk && !mon_sd_prev && cmd_oe) begin
         fr_bits = {fr_bits[46:0], cmd_out};
         fr_n++;
         if (fr_n == 48) begin
            fr_n = 0;
            n_cmp++;
            if (fr_exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL frame: got %h, required no frame", fr_bits);
            end else begin
               fe = fr_exp_q.pop_front();
               if (fr_bits !== fe) begin
                  n_fail++;
                  $display("FAIL frame: got %h, required %h", fr_bits, fe);
               end
            end
         end
      end
      mon_sd_prev = sd_clk;
      if (rd_valid && rd_exp_q.size() > 0) begin
         re = rd_exp_q.pop_front();
         nm = rd_name_q.pop_front();
         n_cmp++;
         if (readdata !== re) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, readdata, re);
         end
      end
      while (ck_name_q.size() > 0) begin
         a  = ck_act_q.pop_front();
         e  = ck_exp_q.pop_front();
         nm = ck_name_q.pop_front();
         n_cmp++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, a, e);
         end
      end
   end

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      ck_name_q.push_back(n);
      ck_act_q.push_back(act);
      ck_exp_q.push_back(exp);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic read_chk(input logic [2:0] a, input logic [31:0] e, input string n);
      @(negedge clk);
      address = a;
      rd_exp_q.push_back(e);
      rd_name_q.push_back(n);
      rd_strobe = 1'b1;
      @(negedge clk);
      rd_strobe = 1'b0;
   endtask

   task automatic wait_oe(input logic lvl);
      for (int i = 0; i < Budget; i++) begin
         @(negedge clk);
         if (cmd_oe == lvl) return;
      end
      chk("wait_cmd_oe", 64'(cmd_oe), 64'(lvl));
   endtask

   task automatic count_sd_rises(input int n);
      int   c = 0;
      logic p = sd_clk;
      for (int i = 0; i < Budget; i++) begin
         @(negedge clk);
         if (!p && sd_clk) c++;
         p = sd_clk;
         if (c == n) return;
      end
      chk("wait_sd_rise", 64'(c), 64'(n));
   endtask

   task automatic wait_sd_fall();
      logic p = sd_clk;
      for (int i = 0; i < Budget; i++) begin
         @(negedge clk);
         if (p && !sd_clk) return;
         p = sd_clk;
      end
      chk("wait_sd_fall", 64'(sd_clk), 64'(~p));
   endtask

   task automatic wait_done();
      @(negedge clk);
      address = 3'd2;
      for (int i = 0; i < Budget; i++) begin
         @(negedge clk);
         if (readdata[3]) return;
      end
      chk("wait_done", 64'(readdata[3]), 64'd1);
   endtask

   // Card model: start driving the response on the second falling edge after release.
   task automatic card_reply(input logic [47:0] r);
      wait_oe(1'b1);
      wait_oe(1'b0);
      wait_sd_fall();
      for (int i = 47; i >= 0; i--) begin
         wait_sd_fall();
         cmd_in = r[i];
      end
      wait_sd_fall();
      cmd_in = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; cmd_in = 1'b1;
      #3 reset_n = 1'b0;
      #1;
      chk("rst_sd_clk", 64'(sd_clk), 64'd0);
      chk("rst_cmd_oe", 64'(cmd_oe), 64'd0);
      chk("rst_cmd_out", 64'(cmd_out), 64'd1);
      chk("rst_readdata", 64'(readdata), 64'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      read_chk(3'd0, 32'h0, "rst_arg");
      read_chk(3'd1, 32'h0, "rst_cmd");
      read_chk(3'd2, 32'h0, "rst_status");
      read_chk(3'd3, 32'h0, "rst_resp");
      read_chk(3'd4, 32'h0, "rst_resp_idx");
      read_chk(3'd6, 32'h0, "addr6");

      // CMD0, no response
      fr_exp_q.push_back(48'h40_00000000_95);
      bus_write(3'd0, 32'h0);
      bus_write(3'd1, 32'h000);
      wait_oe(1'b1);
      wait_oe(1'b0);
      chk("cmd0_oe_released", 64'(cmd_oe), 64'd0);
      chk("cmd0_out_idle", 64'(cmd_out), 64'd1);
      count_sd_rises(8);
      read_chk(3'd2, 32'h1, "cmd0_busy_after_7_nrc");
      repeat (2 * ClkDiv + 2) @(negedge clk);
      read_chk(3'd2, 32'h8, "cmd0_done");
      read_chk(3'd3, 32'h0, "cmd0_resp_unchanged");

      // CMD8 with good response
      fr_exp_q.push_back(48'h48_000001AA_87);
      bus_write(3'd0, 32'h0000_01AA);
      bus_write(3'd1, 32'h108);
      card_reply(48'h08_000001AA_13);
      wait_done();
      read_chk(3'd2, 32'h8, "cmd8_status");
      read_chk(3'd3, 32'h0000_01AA, "cmd8_resp");
      read_chk(3'd4, 32'h08, "cmd8_resp_idx");
      read_chk(3'd1, 32'h108, "cmd8_cmd_readback");

      // CMD8, response with a flipped bit -> crc_err
      fr_exp_q.push_back(48'h48_000001AA_87);
      bus_write(3'd1, 32'h108);
      card_reply(48'h08_000001AB_13);
      wait_done();
      read_chk(3'd2, 32'hC, "flip_crc_err");
      read_chk(3'd3, 32'h0000_01AB, "flip_resp");

      // Same flipped response with skip_resp_crc
      fr_exp_q.push_back(48'h48_000001AA_87);
      bus_write(3'd1, 32'h308);
      card_reply(48'h08_000001AB_13);
      wait_done();
      read_chk(3'd2, 32'h8, "skip_crc_status");

      // Timeout: cmd_in held high
      fr_exp_q.push_back(48'h48_000001AA_87);
      bus_write(3'd1, 32'h108);
      wait_oe(1'b1);
      wait_oe(1'b0);
      count_sd_rises(63);
      read_chk(3'd2, 32'h1, "ncr_63_no_timeout");
      count_sd_rises(1);
      read_chk(3'd2, 32'h3, "ncr_64_timeout");
      wait_done();
      read_chk(3'd2, 32'hA, "timeout_done");
      read_chk(3'd3, 32'h0000_01AB, "timeout_resp_unchanged");
      read_chk(3'd4, 32'h08, "timeout_idx_unchanged");

      // Writes while busy are ignored
      fr_exp_q.push_back(48'h40_00000000_95);
      bus_write(3'd0, 32'h0);
      bus_write(3'd1, 32'h000);
      wait_oe(1'b1);
      bus_write(3'd0, 32'hDEAD_BEEF);
      bus_write(3'd1, 32'h3FF);
      wait_done();
      read_chk(3'd0, 32'h0, "busy_arg_ignored");
      read_chk(3'd1, 32'h0, "busy_cmd_ignored");

      // Reset in the middle of TX, then CMD0 on the first clk after release
      bus_write(3'd1, 32'h108);
      wait_oe(1'b1);
      count_sd_rises(10);
      reset_n = 1'b0;
      #1;
      chk("midrst_sd_clk", 64'(sd_clk), 64'd0);
      chk("midrst_cmd_oe", 64'(cmd_oe), 64'd0);
      chk("midrst_cmd_out", 64'(cmd_out), 64'd1);
      chk("midrst_readdata", 64'(readdata), 64'd0);
      repeat (3) @(negedge clk);
      chk("midrst_sd_clk_held", 64'(sd_clk), 64'd0);
      fr_exp_q.push_back(48'h40_00000000_95);
      reset_n = 1'b1;
      address = 3'd1; writedata = 32'h0; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      wait_oe(1'b1);
      wait_oe(1'b0);
      wait_done();
      read_chk(3'd2, 32'h8, "post_rst_done");
      read_chk(3'd3, 32'h0, "post_rst_resp");
      read_chk(3'd0, 32'h0, "post_rst_arg");

      repeat (4) @(negedge clk);
      chk("frames_all_seen", 64'(fr_exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
